// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between the requesters, the write arbiter and the FIFO write port.
// master = arbiter side, slave = requester/FIFO side.
interface fifo_wr_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            err;
    logic                          busy;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_din;
    logic                          fifo_full;
    logic                          fifo_wr_ack;
    logic                          fifo_wr_err;

    modport master (
        input  req, req_data, fifo_full, fifo_wr_ack, fifo_wr_err,
        output gnt, err, busy, fifo_wr_en, fifo_din
    );

    modport slave (
        output req, req_data, fifo_full, fifo_wr_ack, fifo_wr_err,
        input  gnt, err, busy, fifo_wr_en, fifo_din
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ requesters.
// One write per transaction; winner gets a gnt or err pulse when it resolves.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int TIMEOUT    = 7
) (
    input  logic               clk,
    input  logic               reset_n,
    fifo_wr_arbiter_if.master  bus
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t                r_state;
    logic [PW-1:0]         r_sel;
    logic [PW-1:0]         r_last;
    logic [3:0]            r_wait_cnt;
    logic [NUM_REQ-1:0]    r_gnt;
    logic [NUM_REQ-1:0]    r_err;
    logic                  r_busy;
    logic                  r_wr_en;
    logic [DATA_WIDTH-1:0] r_din;

    logic [PW-1:0]         w_win;
    logic [PW-1:0]         w_cand;
    logic                  w_found;
    logic [DATA_WIDTH-1:0] w_words [NUM_REQ];
    logic [DATA_WIDTH-1:0] w_data;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_words[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Scan from the farthest candidate back to last+1 so the nearest one wins.
    always_comb begin
        w_win   = '0;
        w_cand  = '0;
        w_found = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_cand = PW'((int'(r_last) + k) % NUM_REQ);
            if (bus.req[w_cand]) begin
                w_win   = w_cand;
                w_found = 1'b1;
            end
        end
        w_data = w_words[w_win];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_sel      <= '0;
            r_last     <= PW'(NUM_REQ - 1);
            r_wait_cnt <= '0;
            r_gnt      <= '0;
            r_err      <= '0;
            r_busy     <= 1'b0;
            r_wr_en    <= 1'b0;
            r_din      <= '0;
        end else begin
            r_gnt   <= '0;
            r_err   <= '0;
            r_wr_en <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_found && !bus.fifo_full) begin
                        r_sel   <= w_win;
                        r_din   <= w_data;
                        r_wr_en <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_wait_cnt <= '0;
                    r_state    <= WAIT;
                end
                WAIT: begin
                    if (bus.fifo_wr_ack) begin
                        r_gnt[r_sel] <= 1'b1;
                        r_last       <= r_sel;
                        r_busy       <= 1'b0;
                        r_state      <= IDLE;
                    end else if (bus.fifo_wr_err ||
                                 r_wait_cnt == 4'(TIMEOUT - 1)) begin
                        r_err[r_sel] <= 1'b1;
                        r_last       <= r_sel;
                        r_busy       <= 1'b0;
                        r_state      <= IDLE;
                    end else if (r_wait_cnt != 4'hF) begin
                        r_wait_cnt <= r_wait_cnt + 4'd1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt        = r_gnt;
    assign bus.err        = r_err;
    assign bus.busy       = r_busy;
    assign bus.fifo_wr_en = r_wr_en;
    assign bus.fifo_din   = r_din;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter with a small FIFO write-port responder.
// Expected words/pulses are queued at stimulus time and popped when they appear.
module tb_fifo_wr_arbiter;
    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_err    = 0;
    int   mode     = 0;
    logic prev_wr  = 1'b0;

    typedef struct {
        logic [3:0]  gnt;
        logic [3:0]  err;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] word [4];

    fifo_wr_arbiter_if #(.DATA_WIDTH(32), .NUM_REQ(4)) bus ();

    fifo_wr_arbiter #(
        .DATA_WIDTH(32),
        .NUM_REQ   (4),
        .TIMEOUT   (7)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [3:0] g, input logic [3:0] e,
                        input logic [31:0] d);
        exp_t x;
        x.gnt  = g;
        x.err  = e;
        x.data = d;
        sb.push_back(x);
    endtask

    // FIFO responder: answers one cycle after wr_en (0 ack, 1 err, 2 silent, 3 both)
    always @(negedge clk) begin
        bus.fifo_wr_ack = 1'b0;
        bus.fifo_wr_err = 1'b0;
        if (!reset_n) begin
            prev_wr = 1'b0;
        end else begin
            if (prev_wr) begin
                bus.fifo_wr_ack = (mode == 0 || mode == 3);
                bus.fifo_wr_err = (mode == 1 || mode == 3);
            end
            prev_wr = bus.fifo_wr_en;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.fifo_wr_en) begin
                if (sb.size() == 0)
                    check("wr_unexpected", 32'(bus.fifo_wr_en), 0);
                else
                    check("fifo_din", bus.fifo_din, sb[0].data);
            end
            if (|bus.gnt || |bus.err) begin
                if (sb.size() == 0) begin
                    check("pulse_unexpected", {bus.gnt, bus.err}, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("gnt", 32'(bus.gnt), 32'(mon_e.gnt));
                    check("err", 32'(bus.err), 32'(mon_e.err));
                end
            end
        end
    end

    task automatic wait_done(output int n, output int nwr);
        bit done = 0;
        n   = 0;
        nwr = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            n++;
            if (bus.fifo_wr_en) nwr++;
            if (|bus.gnt || |bus.err) done = 1;
        end
        if (!done) check("wait_timeout", 32'(n), 0);
    endtask

    initial begin
        int  n;
        int  nwr;
        bit  seen_wr;
        bit  seen_busy;
        word[0] = 32'h1111_0000;
        word[1] = 32'hA5A5_0001;
        word[2] = 32'h2222_0002;
        word[3] = 32'h3333_0003;
        reset_n       = 1'b0;
        bus.req       = '0;
        bus.req_data  = {word[3], word[2], word[1], word[0]};
        bus.fifo_full = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_wr_en", 32'(bus.fifo_wr_en), 0);
        check("rst_din", bus.fifo_din, 0);
        check("rst_gnt", 32'(bus.gnt), 0);
        check("rst_err", 32'(bus.err), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // all four at once: round-robin from requester 0
        for (int g = 0; g < 4; g++) push(4'(1 << g), 4'h0, word[g]);
        bus.req = 4'hF;
        for (int g = 0; g < 4; g++) begin
            wait_done(n, nwr);
            check("t2_order", 32'(bus.gnt), 32'(1 << g));
            check("t2_lat", 32'(n), 3);
            bus.req[g] = 1'b0;
        end

        // single write
        push(4'b0010, 4'h0, word[1]);
        bus.req = 4'b0010;
        wait_done(n, nwr);
        check("t1_lat", 32'(n), 3);
        check("t1_wr_pulses", 32'(nwr), 1);
        bus.req = '0;
        @(negedge clk);
        check("t1_gnt_pulse", 32'(bus.gnt), 0);

        // write error for requester 2, then search resumes at 3
        mode = 1;
        push(4'h0, 4'b0100, word[2]);
        bus.req = 4'b0100;
        wait_done(n, nwr);
        check("t4_gnt_zero", 32'(bus.gnt), 0);
        bus.req = '0;
        mode = 0;
        push(4'b1000, 4'h0, word[3]);
        push(4'b0001, 4'h0, word[0]);
        bus.req = 4'b1001;
        wait_done(n, nwr);
        check("t4_next", 32'(bus.gnt), 32'(4'b1000));
        bus.req[3] = 1'b0;
        wait_done(n, nwr);
        bus.req = '0;

        // FIFO full blocks arbitration
        bus.fifo_full = 1'b1;
        bus.req       = 4'b0001;
        seen_wr       = 0;
        seen_busy     = 0;
        repeat (10) begin
            @(negedge clk);
            seen_wr   |= bus.fifo_wr_en;
            seen_busy |= bus.busy;
        end
        check("t3_no_wr", 32'(seen_wr), 0);
        check("t3_no_busy", 32'(seen_busy), 0);
        mode = 3;
        push(4'b0001, 4'h0, word[0]);
        bus.fifo_full = 1'b0;
        @(negedge clk);
        check("t3_issue", 32'(bus.fifo_wr_en), 1);
        wait_done(n, nwr);
        check("t3_ack_wins", 32'(bus.gnt), 32'(4'b0001));
        bus.req = '0;

        // timeout after TIMEOUT cycles in WAIT
        mode = 2;
        push(4'h0, 4'b0100, word[2]);
        bus.req = 4'b0100;
        wait_done(n, nwr);
        check("t5_cycles", 32'(n), 9);
        check("t5_busy", 32'(bus.busy), 0);
        bus.req = '0;

        // reset in WAIT abandons the write
        push(4'b1000, 4'h0, word[3]);
        bus.req = 4'b1000;
        repeat (3) @(negedge clk);
        check("t6_busy_pre", 32'(bus.busy), 1);
        reset_n = 1'b0;
        #1;
        check("t6_busy", 32'(bus.busy), 0);
        check("t6_din", bus.fifo_din, 0);
        check("t6_pulses", {bus.gnt, bus.err}, 0);
        sb.delete();
        bus.req = 4'b1001;
        repeat (2) @(negedge clk);
        mode = 0;
        push(4'b0001, 4'h0, word[0]);
        push(4'b1000, 4'h0, word[3]);
        reset_n = 1'b1;
        wait_done(n, nwr);
        check("t6_first", 32'(bus.gnt), 32'(4'b0001));
        bus.req[0] = 1'b0;
        wait_done(n, nwr);
        bus.req = '0;

        repeat (5) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
